// File: rtl/dual_port_sync_ram.sv
// ---------------------------------------------------------------------------
// dual_port_sync_ram
//
// Single-clock RAM with one write port (byte enables) and one read port.
// After reset the array is cleared one word per cycle (INIT), then the block
// serves requests (READY). A read of the address being written in the same
// cycle returns write-first data. Out-of-range requests raise addr_err; an
// out-of-range read still completes, returning zero.
//
// Optional build macro:
//   DUAL_PORT_RAM_OUT_REG_EN  adds one output register stage; read latency
//                             becomes 2 and rd_data/rd_valid/read addr_err
//                             move together.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write request
//   wr_addr    in   write address
//   wr_data    in   write data
//   wr_be      in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en      in   read request
//   rd_addr    in   read address
//   rd_data    out  registered read data, held between reads
//   rd_valid   out  one-cycle pulse qualifying rd_data
//   init_done  out  high once the clear sequence has finished
//   addr_err   out  one-cycle pulse for an accepted out-of-range request
//
// state  | meaning
// -------+----------------------------------------------------------
// INIT   | clearing word clr_cnt_q; requests ignored, init_done=0
// READY  | serving reads and writes, init_done=1
// ---------------------------------------------------------------------------
module dual_port_sync_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done,
    output logic                    addr_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    // One extra bit so the range compare also works when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    init_wr;
    logic                    ready;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_fire, rd_fire;
    logic                    wr_in_range, rd_in_range;
    logic                    wr_err_now, rd_err_now;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [DATA_WIDTH-1:0]   rd_data_s1;
    logic                    rd_valid_s1;
    logic                    rd_err_s1;
    logic                    wr_err_s1;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        init_wr   = 1'b0;
        ready     = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign init_done = ready;

    // ---------------- request qualification ----------------
    assign wr_fire     = ready & wr_en;
    assign rd_fire     = ready & rd_en;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
    assign rd_err_now  = rd_fire & ~rd_in_range;

`ifdef DUAL_PORT_RAM_OUT_REG_EN
    // A read error surfaces one cycle later than a write error here; when both
    // ports miss in the same cycle only the (later) read error is reported so
    // the pair still produces a single pulse.
    assign wr_err_now = wr_fire & ~wr_in_range & ~rd_err_now;
`else
    assign wr_err_now = wr_fire & ~wr_in_range;
`endif

    // ---------------- storage (never reset; cleared by INIT) ----------------
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_fire && wr_in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write-first merge: enabled bytes of a colliding write replace the old word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (wr_fire && wr_in_range && (wr_addr == rd_addr)) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_be[b]) begin
                        rd_word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
            rd_err_s1   <= 1'b0;
            wr_err_s1   <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_fire;
            rd_err_s1   <= rd_err_now;
            wr_err_s1   <= wr_err_now;
            if (rd_fire) begin
                rd_data_s1 <= rd_word;
            end
        end
    end

`ifdef DUAL_PORT_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_s2;
    logic                  rd_valid_s2;
    logic                  rd_err_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_s2  <= '0;
            rd_valid_s2 <= 1'b0;
            rd_err_s2   <= 1'b0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            rd_err_s2   <= rd_err_s1;
            if (rd_valid_s1) begin
                rd_data_s2 <= rd_data_s1;
            end
        end
    end

    assign rd_data  = rd_data_s2;
    assign rd_valid = rd_valid_s2;
    assign addr_err = rd_err_s2 | wr_err_s1;
`else
    assign rd_data  = rd_data_s1;
    assign rd_valid = rd_valid_s1;
    assign addr_err = rd_err_s1 | wr_err_s1;
`endif

endmodule
